// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter, busy scoreboard and optional read bypass (WB_BYPASS_EN)
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  output logic                      issue_stall,
  output logic [NUM_REGS-1:0]       busy,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  input  logic [ADDR_W-1:0]         ctrl_readRegA,
  input  logic [ADDR_W-1:0]         ctrl_readRegB,
  input  logic [DATA_W-1:0]         rf_readA,
  input  logic [DATA_W-1:0]         rf_readB,
  output logic [DATA_W-1:0]         data_readRegA,
  output logic [DATA_W-1:0]         data_readRegB
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0]       ptr, gidx, idx;
  logic                xfer;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_data;
  logic [NUM_REGS-1:0] busy_n;
  // scan requesters from ptr with wrap; first valid one wins, nothing is granted during reset
  always_comb begin
    gidx = '0;
    idx = '0;
    xfer = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!xfer && req_valid[idx]) begin
        xfer = 1'b1;
        gidx = idx;
      end
    end
    if (ctrl_reset) xfer = 1'b0;
    req_ready = xfer ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx : '0;
  end
  assign g_addr = req_addr[gidx*ADDR_W +: ADDR_W];
  assign g_data = req_data[gidx*DATA_W +: DATA_W];
  assign issue_stall = issue_valid & busy[issue_addr];
  // next scoreboard: clear on retiring write, then set on accepted issue so the set wins; r0 never busy
  always_comb begin
    busy_n = busy;
    if (ctrl_writeEnable) busy_n[ctrl_writeReg] = 1'b0;
    if (issue_valid && !issue_stall && issue_addr != '0) busy_n[issue_addr] = 1'b1;
    busy_n[0] = 1'b0;
  end
  // rr pointer, registered write stage and scoreboard state
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ptr <= '0;
      busy <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
    end else begin
      busy <= busy_n;
      ctrl_writeEnable <= xfer && g_addr != '0;
      if (xfer) begin
        ptr <= gidx == PW'(NUM_REQ-1) ? '0 : gidx + 1'b1;
        ctrl_writeReg <= g_addr;
        data_writeReg <= g_data;
      end
    end
  end
`ifdef WB_BYPASS_EN
  assign data_readRegA = ctrl_writeEnable && ctrl_writeReg != '0 && ctrl_writeReg == ctrl_readRegA ? data_writeReg : rf_readA;
  assign data_readRegB = ctrl_writeEnable && ctrl_writeReg != '0 && ctrl_writeReg == ctrl_readRegB ? data_writeReg : rf_readB;
`else
  logic unused_rd;
  assign unused_rd = ^{ctrl_readRegA, ctrl_readRegB};
  assign data_readRegA = rf_readA;
  assign data_readRegB = rf_readB;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed bench for regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;
  localparam int N = 3, DW = 32, AW = 5, NR = 32;
  logic clock = 1'b0;
  logic ctrl_reset;
  logic [N-1:0] req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic issue_valid, issue_stall;
  logic [AW-1:0] issue_addr;
  logic [NR-1:0] busy;
  logic ctrl_writeEnable;
  logic [AW-1:0] ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [DW-1:0] data_writeReg, rf_readA, rf_readB, data_readRegA, data_readRegB;
  int checks = 0, fails = 0;
  int m_ptr;
  logic [NR-1:0] m_busy;
  logic m_we;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .issue_stall(issue_stall), .busy(busy), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .ctrl_readRegA(ctrl_readRegA),
    .ctrl_readRegB(ctrl_readRegB), .rf_readA(rf_readA), .rf_readB(rf_readB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB));

  always #5 clock = ~clock;

  function automatic int grant_of();
    for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r = '0;
    int g = grant_of();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_stall();
    return issue_valid && m_busy[issue_addr];
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_busy = '0; m_we = 1'b0; m_reg = '0; m_data = '0;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [AW-1:0] a0, a1, a2,
                       input logic [DW-1:0] d0, d1, d2, input logic iv, input logic [AW-1:0] ia);
    @(negedge clock);
    req_valid = v; req_addr = {a2, a1, a0}; req_data = {d2, d1, d0};
    issue_valid = iv; issue_addr = ia;
    #1;
  endtask

  task automatic advance();
    int g = grant_of();
    logic st = exp_stall();
    logic [NR-1:0] nb = m_busy;
    if (m_we) nb[m_reg] = 1'b0;
    if (issue_valid && !st && issue_addr != '0) nb[issue_addr] = 1'b1;
    m_busy = nb;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      m_reg = req_addr[g*AW +: AW];
      m_data = req_data[g*DW +: DW];
      m_we = m_reg != '0;
    end else m_we = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 3'b000) begin fails++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
    checks++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", ctrl_writeEnable); end
    checks++; if (ctrl_writeReg !== '0 || data_writeReg !== '0) begin fails++; $display("FAIL reset_wreg: got %h/%h expected 0/0", ctrl_writeReg, data_writeReg); end
    checks++; if (busy !== '0) begin fails++; $display("FAIL reset_busy: got %h expected 0", busy); end
    ctrl_reset = 1'b0;
    model_reset();
    drive(3'b001, 5'd4, 5'd0, 5'd0, 32'hA5A5A5A5, 0, 0, 1'b1, 5'd3);
    advance();
    checks++; if (ctrl_writeEnable !== 1'b1 || busy[3] !== 1'b1) begin fails++; $display("FAIL pre_reset_state: got we=%b busy3=%b expected 1/1", ctrl_writeEnable, busy[3]); end
    #2 ctrl_reset = 1'b1;
    #1;
    checks++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL midreset_we: got %b expected 0", ctrl_writeEnable); end
    checks++; if (busy !== '0) begin fails++; $display("FAIL midreset_busy: got %h expected 0", busy); end
    checks++; if (data_writeReg !== '0 || ctrl_writeReg !== '0) begin fails++; $display("FAIL midreset_wdata: got %h/%h expected 0/0", ctrl_writeReg, data_writeReg); end
    checks++; if (req_ready !== 3'b000) begin fails++; $display("FAIL midreset_ready: got %b expected 000", req_ready); end
    @(negedge clock);
    req_valid = '0; issue_valid = 1'b0; ctrl_reset = 1'b0;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    for (int c = 0; c < 6; c++) begin
      drive(3'b111, 5'd10, 5'd11, 5'd12, $urandom, $urandom, $urandom, 1'b0, 5'd0);
      e = 3'b001 << (c % 3);
      checks++; if (req_ready !== e) begin fails++; $display("FAIL rr_grant%0d: got %b expected %b", c, req_ready, e); end
      advance();
      checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== AW'(10 + c % 3) || data_writeReg !== m_data) begin
        fails++; $display("FAIL rr_write%0d: got %b/%0d/%h expected 1/%0d/%h", c, ctrl_writeEnable, ctrl_writeReg, data_writeReg, 10 + c % 3, m_data); end
    end
  endtask

  task automatic test_single();
    drive(3'b010, 5'd0, 5'd5, 5'd0, 0, 32'hDEADBEEF, 0, 1'b0, 5'd0);
    checks++; if (req_ready !== 3'b010) begin fails++; $display("FAIL single_ready: got %b expected 010", req_ready); end
    advance();
    checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'hDEADBEEF) begin
      fails++; $display("FAIL single_write: got %b/%0d/%h expected 1/5/deadbeef", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0);
    checks++; if (req_ready !== 3'b000) begin fails++; $display("FAIL idle_ready: got %b expected 000", req_ready); end
    advance();
    checks++; if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'hDEADBEEF) begin
      fails++; $display("FAIL idle_hold: got %b/%0d/%h expected 0/5/deadbeef", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
  endtask

  task automatic test_reg0();
    logic [NR-1:0] prev = busy;
    drive(3'b001, 5'd0, 0, 0, 32'h11111111, 0, 0, 1'b0, 5'd0);
    checks++; if (req_ready !== 3'b001) begin fails++; $display("FAIL reg0_ready: got %b expected 001", req_ready); end
    advance();
    checks++; if (ctrl_writeEnable !== 1'b0 || busy !== prev) begin fails++; $display("FAIL reg0_write: got we=%b busy=%h expected 0/%h", ctrl_writeEnable, busy, prev); end
    checks++; if (ctrl_writeReg !== 5'd0 || data_writeReg !== 32'h11111111) begin fails++; $display("FAIL reg0_stage: got %0d/%h expected 0/11111111", ctrl_writeReg, data_writeReg); end
  endtask

  task automatic test_scoreboard();
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1, 5'd7);
    checks++; if (issue_stall !== 1'b0) begin fails++; $display("FAIL sb_first_stall: got %b expected 0", issue_stall); end
    advance();
    checks++; if (busy[7] !== 1'b1) begin fails++; $display("FAIL sb_set: got %b expected 1", busy[7]); end
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1, 5'd7);
    checks++; if (issue_stall !== 1'b1) begin fails++; $display("FAIL sb_stall: got %b expected 1", issue_stall); end
    advance();
    checks++; if (busy !== m_busy) begin fails++; $display("FAIL sb_stall_nochange: got %h expected %h", busy, m_busy); end
    drive(3'b001, 5'd7, 0, 0, 32'd77, 0, 0, 1'b0, 5'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0);
    advance();
    checks++; if (busy[7] !== 1'b0) begin fails++; $display("FAIL sb_clear: got %b expected 0", busy[7]); end
    drive(3'b001, 5'd7, 0, 0, 32'd78, 0, 0, 1'b1, 5'd0);
    checks++; if (issue_stall !== 1'b0) begin fails++; $display("FAIL sb_r0_stall: got %b expected 0", issue_stall); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1, 5'd7);
    checks++; if (issue_stall !== 1'b0 || ctrl_writeEnable !== 1'b1) begin fails++; $display("FAIL sb_collide_pre: got stall=%b we=%b expected 0/1", issue_stall, ctrl_writeEnable); end
    advance();
    checks++; if (busy[7] !== 1'b1 || busy[0] !== 1'b0) begin fails++; $display("FAIL sb_set_wins: got b7=%b b0=%b expected 1/0", busy[7], busy[0]); end
    drive(3'b001, 5'd7, 0, 0, 32'd79, 0, 0, 1'b0, 5'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0);
    advance();
    checks++; if (busy[7] !== 1'b0) begin fails++; $display("FAIL sb_clear2: got %b expected 0", busy[7]); end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] ea;
    drive(3'b001, 5'd9, 0, 0, 32'h1234, 0, 0, 1'b0, 5'd0);
    advance();
    ctrl_readRegA = 5'd9; ctrl_readRegB = 5'd3; rf_readA = 32'hCAFEF00D; rf_readB = 32'h0BADBEEF;
    #1;
`ifdef WB_BYPASS_EN
    ea = 32'h1234;
`else
    ea = 32'hCAFEF00D;
`endif
    checks++; if (data_readRegA !== ea) begin fails++; $display("FAIL bypass_a: got %h expected %h", data_readRegA, ea); end
    checks++; if (data_readRegB !== 32'h0BADBEEF) begin fails++; $display("FAIL bypass_b: got %h expected 0badbeef", data_readRegB); end
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0);
    advance();
    checks++; if (data_readRegA !== 32'hCAFEF00D) begin fails++; $display("FAIL bypass_idle: got %h expected cafef00d", data_readRegA); end
    ctrl_readRegA = '0; ctrl_readRegB = '0; rf_readA = '0; rf_readB = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    logic es;
    for (int c = 0; c < 400; c++) begin
      drive(N'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), $urandom, $urandom, $urandom,
            1'($urandom), AW'($urandom));
      er = exp_ready(); es = exp_stall();
      checks++; if (req_ready !== er) begin fails++; $display("FAIL rand_ready%0d: got %b expected %b", c, req_ready, er); end
      checks++; if (issue_stall !== es) begin fails++; $display("FAIL rand_stall%0d: got %b expected %b", c, issue_stall, es); end
      advance();
      checks++; if (ctrl_writeEnable !== m_we || ctrl_writeReg !== m_reg || data_writeReg !== m_data) begin
        fails++; $display("FAIL rand_write%0d: got %b/%0d/%h expected %b/%0d/%h", c, ctrl_writeEnable, ctrl_writeReg, data_writeReg, m_we, m_reg, m_data); end
      checks++; if (busy !== m_busy) begin fails++; $display("FAIL rand_busy%0d: got %h expected %h", c, busy, m_busy); end
    end
  endtask

  initial begin
    ctrl_reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; issue_valid = 1'b0; issue_addr = '0;
    ctrl_readRegA = '0; ctrl_readRegB = '0; rf_readA = '0; rf_readB = '0;
    model_reset();
    repeat (2) @(posedge clock);
    test_reset();
    test_round_robin();
    test_single();
    test_reg0();
    test_scoreboard();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
